// File: rtl/sqrt_square_check_if.sv
// Handshake and result bundle for the sequential squarer.
// The requester drives start/root and observes busy/done and the result fields.
interface sqrt_square_check_if #(
  parameter int WIDTH = 16,
  parameter int FRAC  = 8
);
  logic                     start;
  logic [WIDTH-1:0]         root;
  logic                     busy;
  logic                     done;
  logic [2*WIDTH-1:0]       square;
  logic [WIDTH-FRAC-1:0]    value;
  logic                     ovf;

  modport master (
    output start, root,
    input  busy, done, square, value, ovf
  );

  modport slave (
    input  start, root,
    output busy, done, square, value, ovf
  );
endinterface

// File: rtl/sqrt_square_check.sv
// Sequential radix-2 shift-add squarer: reconstructs the Q(2I).(2F) square of a
// Q(I).F root over WIDTH cycles and recovers the integer operand with saturation.
// Optional build macro SQ_ROUND_EN: round the recovered integer to nearest (ties up)
// instead of truncating; saturation/ovf are then judged on the rounded value.
module sqrt_square_check #(
  parameter int WIDTH = 16,
  parameter int FRAC  = 8
) (
  input logic clk,
  input logic rst,
  sqrt_square_check_if.slave bus
);
  localparam int CW = $clog2(WIDTH);
  localparam int IW = 2*WIDTH - 2*FRAC;   // width of the square's integer part
  localparam int VW = WIDTH - FRAC;       // width of the recovered value
  localparam logic [IW:0] VMAX = {{(IW+1-VW){1'b0}}, {VW{1'b1}}};

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t               state_reg, state_next;
  logic [WIDTH-1:0]     mcand_reg, mcand_next;
  logic [WIDTH-1:0]     mplier_reg, mplier_next;
  logic [2*WIDTH-1:0]   acc_reg, acc_next;
  logic [CW-1:0]        count_reg, count_next;
  logic [2*WIDTH-1:0]   square_reg, square_next;
  logic [VW-1:0]        value_reg, value_next;
  logic                 ovf_reg, ovf_next;
  logic                 done_reg, done_next;

  logic [IW-1:0]        int_part;
  logic [IW:0]          rounded;
  logic                 ovf_calc;
  logic [VW-1:0]        value_calc;

  // Integer recovery from the finished accumulator, with optional rounding and saturation
  always_comb begin
    int_part = acc_reg[2*WIDTH-1:2*FRAC];
`ifdef SQ_ROUND_EN
    rounded  = {1'b0, int_part} + (IW+1)'(acc_reg[2*FRAC-1]);
`else
    rounded  = {1'b0, int_part};
`endif
    ovf_calc   = (rounded > VMAX);
    value_calc = ovf_calc ? {VW{1'b1}} : rounded[VW-1:0];
  end

  // Next-state and datapath: one partial product per RUN cycle, results latched in DONE
  always_comb begin
    state_next  = state_reg;
    mcand_next  = mcand_reg;
    mplier_next = mplier_reg;
    acc_next    = acc_reg;
    count_next  = count_reg;
    square_next = square_reg;
    value_next  = value_reg;
    ovf_next    = ovf_reg;
    done_next   = 1'b0;
    case (state_reg)
      IDLE: begin
        if (bus.start) begin
          mcand_next  = bus.root;
          mplier_next = bus.root;
          acc_next    = '0;
          count_next  = '0;
          state_next  = RUN;
        end
      end
      RUN: begin
        if (mplier_reg[0])
          acc_next = acc_reg + ({{WIDTH{1'b0}}, mcand_reg} << count_reg);
        mplier_next = mplier_reg >> 1;
        count_next  = count_reg + 1'b1;
        if (count_reg == CW'(WIDTH-1))
          state_next = DONE;
      end
      DONE: begin
        square_next = acc_reg;
        value_next  = value_calc;
        ovf_next    = ovf_calc;
        done_next   = 1'b1;
        state_next  = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // State and datapath registers; reset abandons any operation and clears results
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg  <= IDLE;
      mcand_reg  <= '0;
      mplier_reg <= '0;
      acc_reg    <= '0;
      count_reg  <= '0;
      square_reg <= '0;
      value_reg  <= '0;
      ovf_reg    <= 1'b0;
      done_reg   <= 1'b0;
    end else begin
      state_reg  <= state_next;
      mcand_reg  <= mcand_next;
      mplier_reg <= mplier_next;
      acc_reg    <= acc_next;
      count_reg  <= count_next;
      square_reg <= square_next;
      value_reg  <= value_next;
      ovf_reg    <= ovf_next;
      done_reg   <= done_next;
    end
  end

  assign bus.busy   = (state_reg == RUN);
  assign bus.done   = done_reg;
  assign bus.square = square_reg;
  assign bus.value  = value_reg;
  assign bus.ovf    = ovf_reg;
endmodule

// File: tb/tb_sqrt_square_check.sv
// Scoreboard bench for sqrt_square_check: stimulus pushes expected results,
// a negedge monitor pops and compares on every done pulse.
module tb_sqrt_square_check;
  logic clk;
  logic rst;
  int   n_checks;
  int   n_fail;

  typedef struct packed {
    logic [31:0] sq;
    logic [7:0]  val;
    logic        ovf;
  } exp_t;
  exp_t sb_q[$];

`ifdef SQ_ROUND_EN
  localparam logic [7:0] VAL_1A0 = 8'd3;
`else
  localparam logic [7:0] VAL_1A0 = 8'd2;
`endif

  sqrt_square_check_if #(.WIDTH(16), .FRAC(8)) bus ();

  sqrt_square_check #(.WIDTH(16), .FRAC(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic push_exp(input logic [31:0] sq, input logic [7:0] val, input logic ovf);
    exp_t e;
    e.sq = sq; e.val = val; e.ovf = ovf;
    sb_q.push_back(e);
  endtask

  // Monitor: every done pulse must match the oldest outstanding expectation
  always @(negedge clk) begin
    if (!rst && bus.done) begin
      if (sb_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_done: got done with square=0x%0h, expected no done", bus.square);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        check("square", bus.square, e.sq);
        check("value", 32'(bus.value), 32'(e.val));
        check("ovf", 32'(bus.ovf), 32'(e.ovf));
        $display("op done: square=0x%08h value=%0d ovf=%0d (expected 0x%08h %0d %0d)",
                 bus.square, bus.value, bus.ovf, e.sq, e.val, e.ovf);
      end
    end
  end

  // One complete operation with latency, busy-length and output-hold checks
  task automatic run_op(input logic [15:0] r, input logic [31:0] esq,
                        input logic [7:0] ev, input logic eo);
    int busy_n;
    int done_k;
    logic [31:0] held;
    push_exp(esq, ev, eo);
    held = bus.square;
    bus.root  = r;
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    bus.root  = 16'hDEAD;
    busy_n = bus.busy ? 1 : 0;
    done_k = 0;
    for (int k = 1; k <= 40; k++) begin
      @(posedge clk); #1;
      if (bus.busy) busy_n++;
      if (k == 8) check("hold_during_run", bus.square, held);
      if (bus.done) begin
        done_k = k;
        break;
      end
    end
    check("done_latency", 32'(done_k), 32'd17);
    check("busy_cycles", 32'(busy_n), 32'd16);
    @(posedge clk); #1;
    check("done_one_cycle", 32'(bus.done), 32'd0);
  endtask

  initial begin
    n_checks  = 0;
    n_fail    = 0;
    rst       = 1'b1;
    bus.start = 1'b0;
    bus.root  = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_done", 32'(bus.done), 32'd0);
    check("rst_square", bus.square, 32'd0);
    check("rst_value", 32'(bus.value), 32'd0);
    check("rst_ovf", 32'(bus.ovf), 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    run_op(16'h0100, 32'h0001_0000, 8'd1,   1'b0);
    run_op(16'h0F80, 32'h00F0_4000, 8'd240, 1'b0);
    run_op(16'h01A0, 32'h0002_A400, VAL_1A0, 1'b0);
    run_op(16'hFFFF, 32'hFFFE_0001, 8'hFF,  1'b1);
    run_op(16'h1000, 32'h0100_0000, 8'hFF,  1'b1);
    run_op(16'h0000, 32'h0000_0000, 8'd0,   1'b0);

    // Second start while running must be ignored
    begin
      int done_k;
      push_exp(32'h0004_0000, 8'd4, 1'b0);
      bus.root  = 16'h0200;
      bus.start = 1'b1;
      @(posedge clk); #1;
      bus.start = 1'b0;
      done_k = 0;
      for (int k = 1; k <= 40; k++) begin
        @(posedge clk); #1;
        if (k == 5) begin bus.start = 1'b1; bus.root = 16'h0300; end
        if (k == 6) bus.start = 1'b0;
        if (bus.done) begin done_k = k; break; end
      end
      check("ignored_start_latency", 32'(done_k), 32'd17);
      repeat (25) @(posedge clk);
      #1;
    end

    // Reset in the middle of RUN: abandoned op, outputs cleared, no done
    bus.root  = 16'h0300;
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (8) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    check("midrst_busy", 32'(bus.busy), 32'd0);
    check("midrst_done", 32'(bus.done), 32'd0);
    check("midrst_square", bus.square, 32'd0);
    check("midrst_value", 32'(bus.value), 32'd0);
    check("midrst_ovf", 32'(bus.ovf), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (25) @(posedge clk);
    #1;
    run_op(16'h0100, 32'h0001_0000, 8'd1, 1'b0);

    // start held high: back-to-back operations WIDTH+2 cycles apart
    begin
      int first;
      int second;
      push_exp(32'h0001_0000, 8'd1, 1'b0);
      push_exp(32'h0004_0000, 8'd4, 1'b0);
      bus.root  = 16'h0100;
      bus.start = 1'b1;
      @(posedge clk); #1;
      bus.root = 16'h0200;
      first  = 0;
      second = 0;
      for (int k = 1; k <= 60; k++) begin
        @(posedge clk); #1;
        if (first != 0 && k == first + 1) bus.start = 1'b0;
        if (bus.done) begin
          if (first == 0) first = k;
          else begin second = k; break; end
        end
      end
      bus.start = 1'b0;
      check("b2b_first_latency", 32'(first), 32'd17);
      check("b2b_spacing", 32'(second - first), 32'd18);
    end

    repeat (25) @(posedge clk);
    #1;
    check("scoreboard_drained", 32'(sb_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Watchdog so the run always terminates
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog expired");
  end
endmodule
